// File: rtl/cpu_run_ctrl_pkg.sv
// ============================================================================
// Module : cpu_run_ctrl_pkg
// Brief  : Shared state encoding and trace-entry sizing for cpu_run_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int c_drop_w = 16;

  function automatic int trace_width(input int ts_w, input int addr_w, input int data_w);
    return ts_w + addr_w + data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : First-word-fall-through FIFO; a push while full is refused unless
//          a pop happens in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_cnt_w'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // When full, the slot being freed by the pop is the one the push lands in.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// Module : cpu_run_ctrl
// Brief  : CPU run/step/halt controller with cycle budget and a FIFO tracer
//          for watched register-file writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int                  ADDR_W     = 5,
  parameter int                  DATA_W     = 32,
  parameter int                  NUM_REGS   = 32,
  parameter logic [NUM_REGS-1:0] WATCH_MASK = 'h7,
  parameter int                  DEPTH      = 16,
  parameter int                  CNT_W      = 32,
  parameter int                  TS_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          step,
  input  logic                          halt,
  input  logic                          clear,
  input  logic [CNT_W-1:0]              cycle_limit,
  output logic                          cpu_en,
  output logic                          running,
  output logic                          done,
  output logic [CNT_W-1:0]              cycle_count,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          tr_valid,
  input  logic                          tr_ready,
  output logic [TS_W+ADDR_W+DATA_W-1:0] tr_data,
  output logic                          tr_overflow,
  output logic [15:0]                   tr_drops
);

  localparam int c_tr_w = trace_width(TS_W, ADDR_W, DATA_W);

  state_e              r_state;
  state_e              w_state_next;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_next;
  logic [CNT_W-1:0]    w_count_inc;
  logic                w_limit_hit;
  logic                r_cpu_en;
  logic                r_done;
  logic                r_overflow;
  logic [c_drop_w-1:0] r_drops;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [c_tr_w-1:0]   w_entry;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_count_inc  = r_count + CNT_W'(1);
    w_limit_hit  = (cycle_limit != '0) && (w_count_inc == cycle_limit);
    case (r_state)
      S_IDLE: begin
        if (clear)      w_count_next = '0;
        else if (start) w_state_next = S_RUN;
        else if (step)  w_state_next = S_STEP;
      end
      S_RUN: begin
        w_count_next = w_count_inc;
        if (w_limit_hit) w_state_next = S_DONE;
        else if (clear) begin
          w_state_next = S_IDLE;
          w_count_next = '0;
        end else if (halt) w_state_next = S_IDLE;
      end
      S_STEP: begin
        w_count_next = w_count_inc;
        w_state_next = w_limit_hit ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (clear) begin
          w_state_next = S_IDLE;
          w_count_next = '0;
        end else if (start) begin
          w_state_next = S_RUN;
          w_count_next = '0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_cpu_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_cpu_en <= (w_state_next == S_RUN) || (w_state_next == S_STEP);
      r_done   <= (w_state_next == S_DONE);
    end
  end

  assign cpu_en      = r_cpu_en;
  assign running     = r_cpu_en;
  assign done        = r_done;
  assign cycle_count = r_count;

  // Timestamp is the count before this enabled cycle's increment.
  assign w_entry = {r_count[TS_W-1:0], wr_addr, wr_data};
  assign w_push  = r_cpu_en && wr_en
                && ({1'b0, wr_addr} < (ADDR_W+1)'(NUM_REGS))
                && WATCH_MASK[wr_addr];
  assign w_pop   = tr_valid && tr_ready;
  assign w_drop  = w_push && w_fifo_full && !w_pop;

  sync_fifo #(
    .WIDTH (c_tr_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_entry),
    .i_pop   (w_pop),
    .o_dout  (tr_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign tr_valid = !w_fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drops != '1) r_drops <= r_drops + c_drop_w'(1);
    end
  end

  assign tr_overflow = r_overflow;
  assign tr_drops    = r_drops;

endmodule

`default_nettype wire
